// File: rtl/vme_bus_arbiter.sv
// Two-requester arbiter in front of a single VMERdMem/VMEWrMem register-bank slave.
// Each requester buffers one access; grants alternate round-robin and each access can time out.
module vme_bus_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  m0_start,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_busy,
   output logic                  m0_done,
   output logic                  m0_err,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_start,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_busy,
   output logic                  m1_done,
   output logic                  m1_err,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH-1:0] VMEAddr,
   output logic [DATA_WIDTH-1:0] VMEWrData,
   output logic                  VMERdMem,
   output logic                  VMEWrMem,
   input  logic [DATA_WIDTH-1:0] VMERdData,
   input  logic                  VMERdDone,
   input  logic                  VMEWrDone
);

   // state  | meaning
   // IDLE   | no access in flight, pick a pending requester
   // STROBE | single-cycle VMERdMem/VMEWrMem pulse
   // WAIT   | waiting for the matching Done, counting towards timeout
   // ACK    | one-cycle done/err pulse to the granted requester
   typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} state_t;

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t                state, state_nxt;
   logic [1:0]            start;
   logic [1:0]            pend;
   logic                  h_we    [2];
   logic [ADDR_WIDTH-1:0] h_addr  [2];
   logic [DATA_WIDTH-1:0] h_wdata [2];
   logic [DATA_WIDTH-1:0] rdata_q [2];
   logic                  grant, last_grant, sel_grant;
   logic                  we_q, err_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [CW-1:0]         cnt;
   logic                  match_done, timeout;

   assign start      = {m1_start, m0_start};
   assign sel_grant  = pend[~last_grant] ? ~last_grant : last_grant;
   assign match_done = we_q ? VMEWrDone : VMERdDone;
   assign timeout    = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|pend) state_nxt = STROBE;
         STROBE:  state_nxt = WAIT;
         WAIT:    if (match_done || timeout) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pend       <= '0;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt        <= '0;
         for (int n = 0; n < 2; n++) begin
            h_we[n]    <= 1'b0;
            h_addr[n]  <= '0;
            h_wdata[n] <= '0;
            rdata_q[n] <= '0;
         end
      end else begin
         // a start while the slot is still occupied is dropped
         for (int n = 0; n < 2; n++) begin
            if (start[n] && !pend[n]) begin
               pend[n]    <= 1'b1;
               h_we[n]    <= (n == 0) ? m0_we    : m1_we;
               h_addr[n]  <= (n == 0) ? m0_addr  : m1_addr;
               h_wdata[n] <= (n == 0) ? m0_wdata : m1_wdata;
            end
         end
         case (state)
            IDLE: begin
               if (|pend) begin
                  grant           <= sel_grant;
                  pend[sel_grant] <= 1'b0;
                  we_q            <= h_we[sel_grant];
                  addr_q          <= h_addr[sel_grant];
                  wdata_q         <= h_wdata[sel_grant];
               end
            end
            STROBE: cnt <= '0;
            WAIT: begin
               if (match_done) begin
                  err_q <= 1'b0;
                  if (!we_q) rdata_q[grant] <= VMERdData;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (timeout) begin
                     err_q          <= 1'b1;
                     rdata_q[grant] <= '1;
                  end
               end
            end
            ACK:     last_grant <= grant;
            default: ;
         endcase
      end
   end

   always_comb begin
      VMEWrMem  = (state == STROBE) &&  we_q;
      VMERdMem  = (state == STROBE) && !we_q;
      VMEAddr   = addr_q;
      VMEWrData = wdata_q;
      m0_done   = (state == ACK) && (grant == 1'b0);
      m1_done   = (state == ACK) && (grant == 1'b1);
      m0_err    = m0_done && err_q;
      m1_err    = m1_done && err_q;
      m0_busy   = pend[0] || ((state != IDLE) && (grant == 1'b0));
      m1_busy   = pend[1] || ((state != IDLE) && (grant == 1'b1));
      m0_rdata  = rdata_q[0];
      m1_rdata  = rdata_q[1];
   end

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Scoreboard bench for vme_bus_arbiter: stimulus pushes expected strobes/completions,
// negedge monitors pop and compare as the arbiter presents them.
module tb_vme_bus_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          m0_start, m0_we, m1_start, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_busy, m0_done, m0_err, m1_busy, m1_done, m1_err;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] VMEAddr;
   logic [DW-1:0] VMEWrData, VMERdData;
   logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone;

   vme_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .Clk(Clk), .Rst(Rst),
      .m0_start(m0_start), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_busy(m0_busy), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_start(m1_start), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_busy(m1_busy), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
      .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {bit m; bit err; logic [DW-1:0] rdata; int lmin; int lmax; int t0;} comp_t;
   typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} strb_t;
   comp_t comp_q[$];
   strb_t strb_q[$];
   logic [DW-1:0] exp_rd [2];
   int passed = 0;
   int total  = 0;
   bit inflight = 0;

   function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endfunction

   function automatic void unexpected(string name);
      total++;
      $display("FAIL %s: got unexpected event, required none", name);
   endfunction

   // slave model: Done sl_delay cycles after the strobe (0 = never), optional wrong-type Done
   int            sl_delay = 1;
   bit            sl_mismatch = 0;
   logic [DW-1:0] sl_rdata = '0;
   logic          sl_rd = 0, sl_wr = 0, stray_rd = 0, stray_wr = 0;
   int            sl_cd = 0;
   bit            sl_we = 0, sl_mm = 0;

   assign VMERdDone = sl_rd | stray_rd;
   assign VMEWrDone = sl_wr | stray_wr;
   assign VMERdData = sl_rd ? sl_rdata : 32'h0BAD_0BAD;

   always @(negedge Clk) begin
      sl_rd = 1'b0;
      sl_wr = 1'b0;
      if (sl_mm) begin
         if (sl_we) sl_rd = 1'b1; else sl_wr = 1'b1;
         sl_mm = 1'b0;
      end
      if (sl_cd > 0) begin
         sl_cd--;
         if (sl_cd == 0) begin
            if (sl_we) sl_wr = 1'b1; else sl_rd = 1'b1;
         end
      end
      if (VMEWrMem || VMERdMem) begin
         sl_we = VMEWrMem;
         sl_cd = sl_delay;
         sl_mm = sl_mismatch;
      end
   end

   always @(negedge Clk) begin
      if (VMEWrMem || VMERdMem) begin
         check("strobe_overlap", 32'(VMEWrMem & VMERdMem), 32'd0);
         check("one_in_flight", 32'(inflight), 32'd0);
         inflight = 1'b1;
         if (strb_q.size() == 0) unexpected("strobe");
         else begin
            strb_t s;
            s = strb_q.pop_front();
            check("strobe_we", 32'(VMEWrMem), 32'(s.we));
            check("strobe_addr", 32'(VMEAddr), 32'(s.addr));
            if (s.we) check("strobe_wdata", VMEWrData, s.wdata);
         end
      end
      if (m0_done || m1_done) begin
         inflight = 1'b0;
         check("single_done", 32'(m0_done & m1_done), 32'd0);
         if (comp_q.size() == 0) unexpected("done");
         else begin
            comp_t c;
            int lat;
            c = comp_q.pop_front();
            lat = cyc - c.t0;
            check("grant_master", 32'(m1_done), 32'(c.m));
            check("done_err", 32'(c.m ? m1_err : m0_err), 32'(c.err));
            check("done_rdata", c.m ? m1_rdata : m0_rdata, c.rdata);
            if (!(lat >= c.lmin && lat <= c.lmax))
               $display("  latency %0d outside %0d..%0d", lat, c.lmin, c.lmax);
            check("done_latency_ok", 32'(lat >= c.lmin && lat <= c.lmax), 32'd1);
         end
      end
   end

   task automatic expect_acc(input bit m, input bit we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit err, input logic [DW-1:0] rd,
                             input int lmin, input int lmax, input int t0);
      comp_t c;
      strb_t s;
      s.we = we; s.addr = a; s.wdata = d;
      strb_q.push_back(s);
      if (err) exp_rd[m] = '1;
      else if (!we) exp_rd[m] = rd;
      c.m = m; c.err = err; c.rdata = exp_rd[m]; c.lmin = lmin; c.lmax = lmax; c.t0 = t0;
      comp_q.push_back(c);
   endtask

   task automatic drive(input bit m, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (m) begin m1_start = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
      else   begin m0_start = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
   endtask

   task automatic release_starts();
      m0_start = 1'b0;
      m1_start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((comp_q.size() != 0 || strb_q.size() != 0) && n < 400) begin
         @(negedge Clk);
         n++;
      end
      check("drain_queues", 32'(comp_q.size() + strb_q.size()), 32'd0);
      repeat (3) @(negedge Clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      Rst = 1'b1;
      release_starts();
      m0_we = 0; m1_we = 0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check("rst_m0_busy", 32'(m0_busy), 32'd0);
      check("rst_m1_busy", 32'(m1_busy), 32'd0);
      check("rst_done", 32'({m0_done, m1_done, m0_err, m1_err}), 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      check("rst_vme_addr", 32'(VMEAddr), 32'd0);
      check("rst_vme_wdata", VMEWrData, 32'd0);
      check("rst_strobes", 32'({VMERdMem, VMEWrMem}), 32'd0);

      // uncontended write, Done one cycle after strobe, busy c1..c4
      sl_delay = 1;
      t0 = cyc;
      drive(0, 1, 8'h00, 32'hCAFE_F00D);
      expect_acc(0, 1, 8'h00, 32'hCAFE_F00D, 0, '0, 4, 4, t0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge Clk);
         release_starts();
         check($sformatf("t1_busy_c%0d", i), 32'(m0_busy), 32'(i <= 4));
      end
      drain();

      // uncontended read by m1
      sl_rdata = 32'h1234_5678;
      t0 = cyc;
      drive(1, 0, 8'h42, 32'h0);
      expect_acc(1, 0, 8'h42, 32'h0, 0, 32'h1234_5678, 4, 4, t0);
      @(negedge Clk);
      release_starts();
      drain();

      // simultaneous starts, three rounds: m0 then m1 each round
      for (int r = 0; r < 3; r++) begin
         sl_rdata = 32'h5A5A_0000 + 32'(r);
         t0 = cyc;
         drive(0, 1, 8'(r), 32'hA000_0000 + 32'(r));
         drive(1, 0, 8'(8'h80 + r), 32'h0);
         expect_acc(0, 1, 8'(r), 32'hA000_0000 + 32'(r), 0, '0, 4, 4, t0);
         expect_acc(1, 0, 8'(8'h80 + r), 32'h0, 0, 32'h5A5A_0000 + 32'(r), 6, 12, t0);
         @(negedge Clk);
         release_starts();
         drain();
      end

      // read timeout, then a normal read
      sl_delay = 0;
      t0 = cyc;
      drive(0, 0, 8'h33, 32'h0);
      expect_acc(0, 0, 8'h33, 32'h0, 1, '0, TO + 2, TO + 3, t0);
      @(negedge Clk);
      release_starts();
      drain();
      sl_delay = 2;
      sl_rdata = 32'h0F0F_0F0F;
      t0 = cyc;
      drive(0, 0, 8'h34, 32'h0);
      expect_acc(0, 0, 8'h34, 32'h0, 0, 32'h0F0F_0F0F, 5, 5, t0);
      @(negedge Clk);
      release_starts();
      drain();

      // stray Done while idle, dropped second start, wrong-type Done in WAIT
      stray_rd = 1'b1; stray_wr = 1'b1;
      @(negedge Clk);
      stray_rd = 1'b0; stray_wr = 1'b0;
      repeat (2) @(negedge Clk);
      sl_delay = 3;
      sl_mismatch = 1;
      t0 = cyc;
      drive(0, 1, 8'h10, 32'h1111_1111);
      expect_acc(0, 1, 8'h10, 32'h1111_1111, 0, '0, 6, 6, t0);
      @(negedge Clk);
      drive(0, 1, 8'h20, 32'h2222_2222);
      @(negedge Clk);
      release_starts();
      drain();
      repeat (6) @(negedge Clk);
      sl_mismatch = 0;

      // reset while waiting; the late Done must not complete anything
      sl_delay = 6;
      drive(1, 0, 8'h55, 32'h0);
      begin
         strb_t s;
         s.we = 0; s.addr = 8'h55; s.wdata = '0;
         strb_q.push_back(s);
      end
      @(negedge Clk);
      release_starts();
      for (int n = 0; n < 20 && strb_q.size() != 0; n++) @(negedge Clk);
      check("t6_strobe_seen", 32'(strb_q.size()), 32'd0);
      @(negedge Clk);
      check("t6_busy_before_rst", 32'(m1_busy), 32'd1);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      inflight = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      check("t6_busy_after_rst", 32'({m0_busy, m1_busy}), 32'd0);
      check("t6_strobes_after_rst", 32'({VMERdMem, VMEWrMem}), 32'd0);
      check("t6_done_after_rst", 32'({m0_done, m1_done}), 32'd0);
      repeat (8) @(negedge Clk);
      check("t6_idle_busy", 32'({m0_busy, m1_busy}), 32'd0);
      sl_delay = 1;
      sl_rdata = 32'h600D_F00D;
      t0 = cyc;
      drive(1, 0, 8'h56, 32'h0);
      expect_acc(1, 0, 8'h56, 32'h0, 0, 32'h600D_F00D, 4, 4, t0);
      @(negedge Clk);
      release_starts();
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
